// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-port priority and a clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wrr,
  input  logic [NWR*XLEN-1:0] wrdata,
  input  logic                clr,
  output logic                busy
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [NWR-1:0]  wr_act;

  // A write is architectural only when not clearing and not aimed at x0.
  always_comb begin
    wr_act = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_act[j] = wr_en[j] & ~busy_q & (wrr[j*AW +: AW] != '0);
    end
  end

  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        // Later ports overwrite earlier ones, so the highest index wins.
        for (int j = 0; j < NWR; j++) begin
          if (wr_act[j]) begin
            mem_d[wrr[j*AW +: AW]] = wrdata[j*XLEN +: XLEN];
          end
        end
        if (clr) begin
          state_d = StClear;
          idx_d   = AW'(1);
          busy_d  = 1'b1;
        end
      end
      StClear: begin
        mem_d[idx_q] = '0;
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = StIdle;
          idx_d   = AW'(1);
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = AW'(1);
        busy_d  = 1'b0;
      end
    endcase
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      state_q <= StIdle;
      idx_q   <= AW'(1);
      busy_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      rdata[i*XLEN +: XLEN] = mem_q[rr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      // wr_act already excludes x0 and masked writes; last match is the highest port.
      for (int j = 0; j < NWR; j++) begin
        if (wr_act[j] && (wrr[j*AW +: AW] == rr[i*AW +: AW])) begin
          rdata[i*XLEN +: XLEN] = wrdata[j*XLEN +: XLEN];
        end
      end
`endif
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table, randomised writeback against a
// reference array model, clear sequencing, reset mid-clear and a wide 3-read-port build.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rr = '0;
  logic [63:0] rdata;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wrr = '0;
  logic [63:0] wrdata = '0;
  logic        clr = 1'b0;
  logic        busy;

  logic [11:0]  b_rr = '0;
  logic [191:0] b_rdata;
  logic [0:0]   b_wr_en = '0;
  logic [3:0]   b_wrr = '0;
  logic [63:0]  b_wrdata = '0;
  logic         b_busy;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rr     (rr),
    .rdata  (rdata),
    .wr_en  (wr_en),
    .wrr    (wrr),
    .wrdata (wrdata),
    .clr    (clr),
    .busy   (busy)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .rr     (b_rr),
    .rdata  (b_rdata),
    .wr_en  (b_wr_en),
    .wrr    (b_wrr),
    .wrdata (b_wrdata),
    .clr    (1'b0),
    .busy   (b_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: register contents plus number of clear edges still to come.
  logic [31:0] m_reg [32];
  int          m_left = 0;
  logic [63:0] b_exp [16];

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    if (m_left == 0 && a != 5'd0) begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j] && wrr[j*5 +: 5] == a) v = wrdata[j*32 +: 32];
      end
    end
`endif
    return v;
  endfunction

  // Apply the spec's edge rules to the model, then advance one clock.
  task automatic tick();
    if (!rst_n) begin
      for (int a = 0; a < 32; a++) m_reg[a] = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_reg[32 - m_left] = '0;
      m_left--;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j] && wrr[j*5 +: 5] != 5'd0) m_reg[wrr[j*5 +: 5]] = wrdata[j*32 +: 32];
      end
      if (clr) m_left = 31;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input string name);
    for (int p = 0; p < 2; p++) begin
      chk(name, {32'h0, rdata[p*32 +: 32]}, {32'h0, exp_read(rr[p*5 +: 5])});
    end
  endtask

  task automatic sweep_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      rr = {a[4:0], a[4:0]};
      #1;
      chk(name, rdata, 64'h0);
    end
  endtask

  initial begin
    int busy_cnt;
    logic [4:0] ra;

    vt[0] = '{2'b01, 5'd0,  32'hDEADBEEF, 5'd0,  32'h0,        5'd0,  32'h0};
    vt[1] = '{2'b11, 5'd5,  32'h00001111, 5'd5,  32'h00002222, 5'd5,  32'h00002222};
    vt[2] = '{2'b11, 5'd0,  32'h00001111, 5'd0,  32'h00002222, 5'd0,  32'h0};
    vt[3] = '{2'b01, 5'd9,  32'h12345678, 5'd0,  32'h0,        5'd9,  32'h12345678};
    vt[4] = '{2'b10, 5'd0,  32'h0,        5'd10, 32'hCAFEF00D, 5'd10, 32'hCAFEF00D};
    vt[5] = '{2'b11, 5'd3,  32'h0000AAAA, 5'd4,  32'h0000BBBB, 5'd3,  32'h0000AAAA};
    vt[6] = '{2'b00, 5'd9,  32'hFFFFFFFF, 5'd0,  32'h0,        5'd9,  32'h12345678};
    vt[7] = '{2'b11, 5'd5,  32'h77777777, 5'd0,  32'h99999999, 5'd5,  32'h77777777};
    for (int a = 0; a < 32; a++) m_reg[a] = '0;

    // Reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("reset_busy", {63'h0, busy}, 64'h0);
    sweep_zero("reset_read");

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      wr_en  = vt[v].en;
      wrr    = {vt[v].a1, vt[v].a0};
      wrdata = {vt[v].d1, vt[v].d0};
      tick();
      wr_en = '0;
      rr = {vt[v].ra, vt[v].ra};
      #1;
      chk($sformatf("vec%0d_p0", v), {32'h0, rdata[31:0]},  {32'h0, vt[v].exp});
      chk($sformatf("vec%0d_p1", v), {32'h0, rdata[63:32]}, {32'h0, vt[v].exp});
    end

    // Randomised writeback on a random port
    for (int i = 1; i < 32; i++) begin
      wr_en  = 2'b01 << $urandom_range(0, 1);
      wrr    = {i[4:0], i[4:0]};
      wrdata = {$urandom, $urandom};
      tick();
      wr_en = '0;
      rr = {i[4:0], i[4:0]};
      #1;
      check_reads("writeback");
    end
    for (int k = 0; k < 20; k++) begin
      rr = 10'($urandom);
      #1;
      check_reads("random_read");
    end

    // Same-cycle read of the register being written
    wr_en  = 2'b01;
    wrr    = {5'd0, 5'd7};
    wrdata = {32'h0, 32'hA5A5A5A5};
    rr     = {5'd0, 5'd7};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_pre_edge", {32'h0, rdata[31:0]}, {32'h0, 32'hA5A5A5A5});
`else
    chk("bypass_pre_edge", {32'h0, rdata[31:0]}, {32'h0, m_reg[7]});
`endif
    tick();
    wr_en = '0;
    #1;
    chk("bypass_post_edge", {32'h0, rdata[31:0]}, {32'h0, 32'hA5A5A5A5});

    // Clear sequence with writes and a second clr while busy
    for (int a = 1; a < 32; a++) begin
      wr_en  = 2'b01;
      wrr    = {5'd0, a[4:0]};
      wrdata = {32'h0, $urandom | 32'h1};
      tick();
    end
    wr_en = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      busy_cnt++;
      chk("busy_model", {63'h0, busy}, {63'h0, m_left > 0});
      wr_en  = 2'b11;
      wrr    = 10'($urandom);
      wrdata = {$urandom, $urandom};
      ra     = 5'($urandom);
      rr     = {ra, wrr[4:0]};
      clr    = (c == 5);
      #1;
      check_reads("read_in_clear");
      tick();
      clr   = 1'b0;
      wr_en = '0;
    end
    chk("busy_len", 64'(busy_cnt), 64'd31);
    sweep_zero("clear_zero");

    // Write and clr together, then reset ten cycles into the clear
    wr_en  = 2'b01;
    wrr    = {5'd0, 5'd20};
    wrdata = {32'h0, 32'h5555AAAA};
    clr    = 1'b1;
    tick();
    clr   = 1'b0;
    wr_en = '0;
    rr    = {5'd0, 5'd20};
    #1;
    chk("write_with_clr", {32'h0, rdata[31:0]}, {32'h0, 32'h5555AAAA});
    chk("clr_busy", {63'h0, busy}, 64'h1);
    for (int c = 0; c < 9; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_busy", {63'h0, busy}, 64'h0);
    sweep_zero("rst_mid_zero");
    tick();
    chk("rst_no_resume", {63'h0, busy}, 64'h0);

    // Wide configuration: XLEN=64, NREGS=16, NRD=3
    b_rr = {4'd15, 4'd5, 4'd0};
    #1;
    chk("b_reset", b_rdata[63:0] | b_rdata[127:64] | b_rdata[191:128], 64'h0);
    b_exp[0] = '0;
    for (int i = 1; i < 16; i++) begin
      b_exp[i] = {$urandom, $urandom};
      b_wr_en  = 1'b1;
      b_wrr    = i[3:0];
      b_wrdata = b_exp[i];
      tick();
      b_wr_en = 1'b0;
      b_rr = {i[3:0], i[3:0], i[3:0]};
      #1;
      for (int p = 0; p < 3; p++) chk($sformatf("b_wb_p%0d", p), b_rdata[p*64 +: 64], b_exp[i]);
    end
    for (int k = 0; k < 10; k++) begin
      b_rr = 12'($urandom);
      #1;
      for (int p = 0; p < 3; p++) chk("b_rand", b_rdata[p*64 +: 64], b_exp[b_rr[p*4 +: 4]]);
    end
    chk("b_busy", {63'h0, b_busy}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the CPU core.
- Generalises the fixed 32x32, 2-read/1-write regfile to configurable width, depth, read-port count and write-port count.
- Adds deterministic write-port priority, optional write-to-read bypass, and a multi-cycle software-triggered clear sequencer with a busy flag.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, >= 4; register 0 hardwired to zero.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.
- AW, $clog2(NREGS), address width; derived, do not override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- rr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- wr_en  in  NWR  per-port write enable.
- wrr  in  NWR*AW  write addresses, packed as for rr.
- wrdata  in  NWR*XLEN  write data, packed as for rdata.
- clr  in  1  clear request, sampled at posedge.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset: rst_n low at a posedge sets every register to 0, FSM to IDLE, clear index to 1, busy to 0. rdata is combinational, so it reads 0 during and after reset.
- Reads:
  - Combinational and asynchronous to clk: rdata[i] = reg[rr[i]].
  - Address 0 always returns 0.
  - A write performed at posedge is visible on the read ports after that edge.
- Writes:
  - At posedge, for each port j with wr_en[j]=1 and wrr[j]!=0, reg[wrr[j]] <= wrdata[j].
  - Writes to address 0 are discarded.
  - If two ports target the same non-zero address in one cycle, the higher port index wins. The lower-index write is dropped and has no partial effect.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr=1 at posedge. That edge sets idx=1 and busy=1; no register is zeroed on that edge.
  - In CLEAR, each posedge sets reg[idx] <= 0. If idx==NREGS-1, the FSM returns to IDLE and busy drops. Otherwise idx increments.
  - busy is high for exactly NREGS-1 cycles. The default config zeroes registers 1..31 on 31 consecutive edges.
  - While busy=1, all wr_en are masked internally, so no architectural write occurs.
  - clr asserted while in CLEAR is ignored (no restart).
  - clr and wr_en asserted together in IDLE: the write is performed on that edge, then the clear begins.
  - Reads during CLEAR return current array contents, so a mix of cleared and uncleared registers is visible.
- Reset mid-clear: every register is zeroed, the FSM goes to IDLE, busy=0 on the next cycle. The sequence does not resume.
- Widths: addresses are used unmodified; AW covers exactly NREGS entries, so no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data combinationally when wr_en[j]=1, busy=0, wrr[j]==rr[i] and rr[i]!=0.
  - On a multi-port match, the highest-index writer is forwarded, consistent with write priority.
  - Address 0 is never bypassed.
  - Masked writes (busy=1) are never forwarded.
- Undefined: reads see only stored contents; new data appears after the write edge.

Test Plan:
- Reset, default config: pulse rst_n low for one posedge. Sweep rr over 0..31 on both ports -> rdata all 32'h0; busy=0.
- x0: write 32'hDEADBEEF to wrr=0, then read rr=0 on all ports -> 32'h0.
- Writeback: for i=1..31, write a random value to reg i, then read it on every read port the next cycle -> matches. Repeat with XLEN=64, NREGS=16, NRD=3.
- Write conflict, NWR=2: port0 writes 32'h1111 and port1 writes 32'h2222 to reg 5 in the same cycle -> reg5=32'h2222. Same-cycle writes to reg 0 from both ports -> reg0 reads 0.
- Bypass:
  - With REGFILE_BYPASS_EN: wr_en=1, wrr=7, wrdata=32'hA5A5A5A5 and rr0=7 in the same cycle -> rdata0=32'hA5A5A5A5 before the edge.
  - Without the macro: rdata0 holds the old value until after the edge.
- Clear:
  - Fill regs 1..31 with nonzero values, pulse clr for one cycle -> busy high for exactly 31 cycles.
  - Writes issued while busy have no effect.
  - After busy falls, every register reads 0.
  - A second clr while busy does not extend busy.
- Reset mid-clear: assert rst_n low 10 cycles into CLEAR -> next cycle busy=0 and all registers read 0.
